exclusive_min_n: RTL and testbench
==================================

Name: exclusive_min_n

Overview:
- N-channel, clocked generalisation of the 2-input exclusive-min temporal primitive used in the race-logic datapath.
- Within each gamma epoch, emits a single output spike only if exactly one channel is strictly first to fire.
- Reports the winner index and its arrival time; a tie for first blocks the output.
- Selectable event encoding (rising edge, falling edge, pulse level) and a self-timed epoch with an optional local epoch reset.

Parameters:
N, 4, number of input channels (>=2)
EDGE_MODE, 0, event encoding: 0 rising edge, 1 falling edge, 2 pulse (input sampled high)
GAMMA, 16, epoch length in aclk cycles (>=2)
TW, $clog2(GAMMA), width of arrival-time field

Ports:
aclk  input  1  clock; all logic on its rising edge
grst_n  input  1  global reset, synchronous, active-low
rst  input  1  local epoch reset, synchronous, active-high; starts a new epoch
in  input  N  channel inputs, synchronous to aclk
q  output  1  one-cycle spike: unique earliest channel this epoch
q_idx  output  $clog2(N)  winning channel index, valid with q and held afterwards
q_time  output  TW  epoch time of the winning event, valid with q and held afterwards
tie  output  1  one-cycle pulse: two or more channels fired first in the same cycle
epoch_end  output  1  one-cycle pulse: epoch closed (wrap or rst)

Behaviour:
- Reset (grst_n=0 at an edge): q=0, tie=0, epoch_end=0, q_idx=0, q_time=0, timer=0, state=ARMED, prev<=in (no spurious edge on release).
- Event detect per channel, at sampling edge k:
  - EDGE_MODE 0: in & ~prev.
  - EDGE_MODE 1: ~in & prev.
  - EDGE_MODE 2: in.
  - prev<=in every cycle.
- Timer: counts 0..GAMMA-1 and increments every cycle. Time t = timer value at the sampling edge. At GAMMA-1 it wraps to 0 and epoch_end pulses the following cycle.
- FSM states: ARMED, WON, BLOCKED.
  - ARMED, exactly one event: go to WON. Next cycle q=1, q_idx=channel, q_time=t.
  - ARMED, two or more events in the same cycle: go to BLOCKED. Next cycle tie=1; q stays 0; q_idx/q_time unchanged.
  - ARMED, no event: stay.
  - WON / BLOCKED: all further events ignored until the epoch closes.
- Epoch close (timer wrap or rst=1): state<=ARMED, timer<=0, epoch_end=1 next cycle.
- Latency: q and tie are registered and assert exactly 1 cycle after the sampling edge. Each pulses for exactly 1 cycle, at most once per epoch.
- q_idx/q_time hold their last values until the next win or grst_n. They are not cleared at epoch boundaries.
- Simultaneous events:
  - rst=1 with an event in the same cycle: rst wins; event discarded, no q/tie. Timer goes to 0 and prev<=in, so a level held across rst is not re-detected as an edge.
  - Wrap cycle (t=GAMMA-1) with an event in ARMED: event belongs to the closing epoch. q (or tie) and epoch_end both pulse next cycle; new epoch starts ARMED.
  - grst_n=0 overrides rst and everything else.
- In pulse mode, a channel held high across an epoch boundary fires again at t=0 of the new epoch. This is intended.
- No combinational path from in to any output.

Test Plan:
- EDGE_MODE=0, N=4, GAMMA=16: after grst_n, ch2 rises at t=3, ch0 at t=5 -> q=1 for one cycle at t=4, q_idx=2, q_time=3; tie never set; epoch_end pulses once after t=15.
- Tie: ch1 and ch3 rise at t=6 -> tie=1 one cycle, q=0 for the whole epoch; a later ch0 rise at t=8 is ignored.
- No events for a full epoch -> q=0, tie=0, epoch_end pulses every 16 cycles, q_idx/q_time keep previous values.
- EDGE_MODE=1, all inputs held 1 through reset: ch1 falls at t=2 -> q_idx=1, q_time=2; reset release alone produces no event.
- EDGE_MODE=2: ch0 high at t=15 (wrap cycle) -> q and epoch_end both pulse next cycle with q_time=15. ch0 held high into the new epoch -> fresh q at t=1 with q_time=0.
- rst mid-epoch: rst=1 in the same cycle ch3 rises at t=4 -> no q, epoch_end next cycle, timer restarts at 0. ch2 rises 2 cycles later -> q_idx=2, q_time=1. grst_n low mid-epoch -> all outputs 0 next cycle.

Source files
------------

// File: rtl/exclusive_min_n.sv
// N-channel exclusive-min race-logic primitive: within each self-timed gamma
// epoch, reports the unique earliest-firing channel and its arrival time.
module exclusive_min_n #(
  parameter int N         = 4,
  parameter int EDGE_MODE = 0,
  parameter int GAMMA     = 16,
  parameter int TW        = $clog2(GAMMA)
) (
  input  logic                 aclk,
  input  logic                 grst_n,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  output logic                 q,
  output logic [$clog2(N)-1:0] q_idx,
  output logic [TW-1:0]        q_time,
  output logic                 tie,
  output logic                 epoch_end
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    ARMED,
    WON,
    BLOCKED
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    prev;
  logic [N-1:0]    ev;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   ev_idx;
  logic            wrap;
  logic            one_ev;
  logic            multi_ev;
  logic            q_nxt;
  logic            tie_nxt;

  always_comb begin
    if (EDGE_MODE == 0)      ev = in & ~prev;
    else if (EDGE_MODE == 1) ev = ~in & prev;
    else                     ev = in;
  end

  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
  always_comb begin
    one_ev   = (ev != '0) && ((ev & (ev - N'(1))) == '0);
    multi_ev = (ev != '0) && !one_ev;
    ev_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ev[i]) ev_idx = IW'(i);
    end
  end

  assign wrap = (timer == TW'(GAMMA - 1));

  always_comb begin
    state_nxt = state;
    q_nxt     = 1'b0;
    tie_nxt   = 1'b0;
    if (rst) begin
      state_nxt = ARMED;
    end else begin
      if (state == ARMED) begin
        if (one_ev) begin
          state_nxt = WON;
          q_nxt     = 1'b1;
        end else if (multi_ev) begin
          state_nxt = BLOCKED;
          tie_nxt   = 1'b1;
        end
      end
      // An event on the wrap cycle still belongs to the closing epoch.
      if (wrap) state_nxt = ARMED;
    end
  end

  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      state     <= ARMED;
      timer     <= '0;
      prev      <= in;
      q         <= 1'b0;
      tie       <= 1'b0;
      epoch_end <= 1'b0;
      q_idx     <= '0;
      q_time    <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= in;
      q         <= q_nxt;
      tie       <= tie_nxt;
      epoch_end <= rst | wrap;
      timer     <= (rst || wrap) ? '0 : timer + TW'(1);
      if (q_nxt) begin
        q_idx  <= ev_idx;
        q_time <= timer;
      end
    end
  end

endmodule

// File: tb/tb_exclusive_min_n.sv
// Bench for exclusive_min_n: one instance per event encoding on shared stimulus,
// a per-cycle scoreboard plus directed checks at the interesting cycles.
module tb_exclusive_min_n;

  logic       aclk = 1'b0;
  logic       grst_n;
  logic       rst;
  logic [3:0] in;
  logic       q   [3];
  logic       tie [3];
  logic       ee  [3];
  logic [1:0] qi  [3];
  logic [3:0] qt  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    exclusive_min_n #(.N(4), .EDGE_MODE(m), .GAMMA(16)) dut (
      .aclk     (aclk),
      .grst_n   (grst_n),
      .rst      (rst),
      .in       (in),
      .q        (q[m]),
      .q_idx    (qi[m]),
      .q_time   (qt[m]),
      .tie      (tie[m]),
      .epoch_end(ee[m])
    );
  end

  typedef struct packed {
    logic       q;
    logic       tie;
    logic       ee;
    logic [1:0] idx;
    logic [3:0] tm;
  } exp_t;

  exp_t sb[$];

  // Reference model, one slot per encoding.
  logic [3:0] m_prev  [3];
  int         m_timer [3];
  logic       m_armed [3];
  logic [1:0] m_idx   [3];
  logic [3:0] m_tm    [3];

  always @(posedge aclk) begin
    exp_t e;
    logic [3:0] evs;
    int n;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: evs = in & ~m_prev[d];
        1: evs = ~in & m_prev[d];
        default: evs = in;
      endcase
      n = $countones(evs);
      e = '0;
      if (!grst_n) begin
        m_timer[d] = 0;
        m_armed[d] = 1'b1;
        m_idx[d]   = 2'd0;
        m_tm[d]    = 4'd0;
      end else begin
        e.ee = rst || (m_timer[d] == 15);
        if (!rst && m_armed[d] && n == 1) begin
          e.q = 1'b1;
          for (int c = 0; c < 4; c++) if (evs[c]) m_idx[d] = 2'(c);
          m_tm[d] = 4'(m_timer[d]);
        end
        if (!rst && m_armed[d] && n > 1) e.tie = 1'b1;
        if (rst || m_timer[d] == 15) m_armed[d] = 1'b1;
        else if (n != 0)             m_armed[d] = 1'b0;
        m_timer[d] = rst ? 0 : (m_timer[d] + 1) % 16;
      end
      m_prev[d] = in;
      e.idx = m_idx[d];
      e.tm  = m_tm[d];
      sb.push_back(e);
    end
  end

  always @(negedge aclk) begin
    exp_t e;
    exp_t o;
    for (int d = 0; d < 3; d++) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        o = {q[d], tie[d], ee[d], qi[d], qt[d]};
        vectors++;
        assert (o === e) else begin
          miscompares++;
          $error("FAIL sb_mode%0d observed=%h expected=%h", d, o, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Leaves the bench at the negedge just before the t=0 sampling edge.
  task automatic greset(input logic [3:0] v);
    grst_n = 1'b0;
    rst    = 1'b0;
    in     = v;
    tick(2);
    grst_n = 1'b1;
  endtask

  initial begin
    grst_n = 1'b0;
    rst    = 1'b0;
    in     = 4'b0000;

    // Rising edge: ch2 at t=3 wins, ch0 at t=5 ignored.
    greset(4'b0000);
    chk("a_rst_q", q[0], 1'b0);
    chk("a_rst_idx", qi[0], 2'd0);
    tick(3); in = 4'b0100;
    tick(1);
    chk("a_q", q[0], 1'b1);
    chk("a_idx", qi[0], 2'd2);
    chk("a_time", qt[0], 4'd3);
    tick(1); in = 4'b0101;
    chk("a_q_once", q[0], 1'b0);
    for (int t = 6; t <= 16; t++) begin
      tick(1);
      chk("a_q_quiet", q[0], 1'b0);
      chk("a_no_tie", tie[0], 1'b0);
      chk("a_ee", ee[0], (t == 16));
    end

    // Tie: ch1 and ch3 rise at t=6, later ch0 rise at t=8 ignored.
    tick(1); in = 4'b0000;
    tick(5); in = 4'b1010;
    tick(1);
    chk("b_tie", tie[0], 1'b1);
    chk("b_q", q[0], 1'b0);
    tick(1); in = 4'b1011;
    chk("b_tie_once", tie[0], 1'b0);
    for (int t = 9; t <= 16; t++) begin
      tick(1);
      chk("b_q_blocked", q[0], 1'b0);
      chk("b_ee", ee[0], (t == 16));
    end
    chk("b_idx_held", qi[0], 2'd2);

    // Quiet epoch: outputs stay low, one epoch_end, winner fields held.
    for (int t = 1; t <= 16; t++) begin
      tick(1);
      chk("c_q", q[0], 1'b0);
      chk("c_tie", tie[0], 1'b0);
      chk("c_ee", ee[0], (t == 16));
    end
    chk("c_idx_held", qi[0], 2'd2);
    chk("c_time_held", qt[0], 4'd3);

    // Falling edge with all inputs high through reset.
    greset(4'b1111);
    chk("d_rst_idx", qi[1], 2'd0);
    chk("d_rst_time", qt[1], 4'd0);
    tick(1);
    chk("d_no_release_ev", q[1], 1'b0);
    chk("d_no_release_tie", tie[1], 1'b0);
    tick(1); in = 4'b1101;
    tick(1);
    chk("d_q", q[1], 1'b1);
    chk("d_idx", qi[1], 2'd1);
    chk("d_time", qt[1], 4'd2);

    // Pulse mode: event on the wrap cycle, then held level fires again at t=0.
    greset(4'b0000);
    tick(15); in = 4'b0001;
    tick(1);
    chk("e_q_wrap", q[2], 1'b1);
    chk("e_ee_wrap", ee[2], 1'b1);
    chk("e_time_wrap", qt[2], 4'd15);
    chk("e_idx_wrap", qi[2], 2'd0);
    tick(1);
    chk("e_q_new", q[2], 1'b1);
    chk("e_time_new", qt[2], 4'd0);
    chk("e_ee_new", ee[2], 1'b0);

    // Local reset coinciding with a ch3 rise, then ch2 wins at t=1.
    greset(4'b0000);
    tick(4); in = 4'b1000; rst = 1'b1;
    tick(1); rst = 1'b0;
    chk("f_q_rst", q[0], 1'b0);
    chk("f_ee_rst", ee[0], 1'b1);
    tick(1); in = 4'b1100;
    chk("f_no_reedge", q[0], 1'b0);
    tick(1);
    chk("f_q", q[0], 1'b1);
    chk("f_idx", qi[0], 2'd2);
    chk("f_time", qt[0], 4'd1);

    // Global reset mid-epoch clears everything.
    grst_n = 1'b0; in = 4'b1111;
    tick(1);
    for (int d = 0; d < 3; d++) begin
      chk("g_q", q[d], 1'b0);
      chk("g_tie", tie[d], 1'b0);
      chk("g_ee", ee[d], 1'b0);
      chk("g_idx", qi[d], 2'd0);
      chk("g_time", qt[d], 4'd0);
    end
    grst_n = 1'b1;
    tick(3); in = 4'b0010;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
